// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed, XOR-checksummed byte stream into imem word by word,
// and holds the core in reset until a complete image with a good checksum has arrived.
module imem_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              error_o
);
    localparam int IW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT);
    localparam logic [IW-1:0] TMAX = IW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [16:0] MAXW = 17'(MAX_WORDS);
    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d, cnt_q, cnt_d;
    logic [31:0]       word_q, word_d, wdata_q, wdata_d;
    logic [1:0]        byte_q, byte_d;
    logic [7:0]        csum_q, csum_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              acc, timed;
    assign rx_ready_o   = state_q != S_DONE && state_q != S_ERR;
    assign done_o       = state_q == S_DONE;
    assign error_o      = state_q == S_ERR;
    assign cpu_rst_o    = state_q != S_DONE;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign acc          = rx_valid_i && rx_ready_o;
    assign timed        = state_q == S_LEN1 || state_q == S_DATA || state_q == S_CSUM;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        idle_d  = (acc || !timed) ? '0 : idle_q + 1'b1;
        if (acc) begin
            case (state_q)
                S_LEN0: begin
                    len_d[7:0] = rx_data_i;
                    state_d    = S_LEN1;
                end
                S_LEN1: begin
                    len_d   = {rx_data_i, len_q[7:0]};
                    state_d = (len_d == '0 || {1'b0, len_d} > MAXW) ? S_ERR : S_DATA;
                end
                S_DATA: begin
                    word_d[{byte_q, 3'b000} +: 8] = rx_data_i;
                    csum_d = csum_q ^ rx_data_i;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = word_d;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = cnt_q == len_q - 16'd1 ? S_CSUM : S_DATA;
                    end
                end
                S_CSUM:  state_d = rx_data_i == csum_q ? S_DONE : S_ERR;
                default: ;
            endcase
        end
        // an idle counter sitting at TIMEOUT-1 without a byte means TIMEOUT idle cycles have elapsed
        if (TIMEOUT != 0 && timed && !acc && idle_q == TMAX) state_d = S_ERR;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LEN0;
            len_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            byte_q  <= '0;
            csum_q  <= '0;
            idle_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            csum_q  <= csum_d;
            idle_q  <= idle_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
        end
    end
endmodule
